// File: rtl/sys_ctrl_pkg.sv
// Shared constants for the UART command path: command bytes, cmd_code
// encodings (also used by the control FSM) and the frame decoder states.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_BYTE_WR  = 8'hAA;
  localparam logic [7:0] CMD_BYTE_RD  = 8'hBB;
  localparam logic [7:0] CMD_BYTE_ALU = 8'hCC;
  localparam logic [7:0] CMD_BYTE_FUN = 8'hDD;

  localparam logic [2:0] CMD_NONE    = 3'b000;
  localparam logic [2:0] CMD_REG_WR  = 3'b001;
  localparam logic [2:0] CMD_REG_RD  = 3'b010;
  localparam logic [2:0] CMD_ALU_OP  = 3'b011;
  localparam logic [2:0] CMD_ALU_NOP = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GET_ADDR  = 3'd1,
    ST_GET_WDATA = 3'd2,
    ST_GET_OPA   = 3'd3,
    ST_GET_OPB   = 3'd4,
    ST_GET_FUN   = 3'd5
  } dec_state_e;

endpackage

// File: rtl/frame_timeout_cnt.sv
// Inter-byte idle counter. Counts enabled cycles since the last clear and
// flags expiry once the count reaches TIMEOUT_CYCLES. Saturates, never wraps.
// TIMEOUT_CYCLES = 0 disables expiry entirely.
module frame_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;

  // Idle count: clear wins over increment, hold at the limit
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)                       cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (en && (cnt != LIMIT))  cnt <= cnt + 1'b1;
  end

  assign expire = (TIMEOUT_CYCLES != 0) && (cnt == LIMIT);

endmodule

// File: rtl/cmd_frame_decoder.sv
// Command frame decoder: recognises the command byte while the control FSM
// allows it, then collects the frame's field bytes into held registers.
// All outputs are registered; an idle timeout aborts half-received frames.
module cmd_frame_decoder
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned FUN_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_data_vld,
  input  logic                  cmd_analyze_en,
  output logic [2:0]            cmd_code,
  output logic [ADDR_WIDTH-1:0] frame_addr,
  output logic [DATA_WIDTH-1:0] frame_wdata,
  output logic [DATA_WIDTH-1:0] frame_op_a,
  output logic [DATA_WIDTH-1:0] frame_op_b,
  output logic [FUN_WIDTH-1:0]  frame_fun,
  output logic                  field_vld,
  output logic                  frame_done,
  output logic                  frame_err
);

  dec_state_e            state, state_n;
  logic [2:0]            cmd_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] wdata_n, opa_n, opb_n;
  logic [FUN_WIDTH-1:0]  fun_n;
  logic                  fvld_n, done_n, err_n;
  logic                  tmo_clr, tmo_en, tmo_expire;

  // Counter is held clear in IDLE (so it starts from zero on entry) and on
  // every byte taken in a field state, which also lets a byte beat expiry.
  assign tmo_en  = (state != ST_IDLE);
  assign tmo_clr = (state == ST_IDLE) || rx_data_vld;

  frame_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .CLK    (CLK),
    .RST    (RST),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state       <= ST_IDLE;
      cmd_code    <= CMD_NONE;
      frame_addr  <= '0;
      frame_wdata <= '0;
      frame_op_a  <= '0;
      frame_op_b  <= '0;
      frame_fun   <= '0;
      field_vld   <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_n;
      cmd_code    <= cmd_n;
      frame_addr  <= addr_n;
      frame_wdata <= wdata_n;
      frame_op_a  <= opa_n;
      frame_op_b  <= opb_n;
      frame_fun   <= fun_n;
      field_vld   <= fvld_n;
      frame_done  <= done_n;
      frame_err   <= err_n;
    end
  end

  // Next state, next output values; pulses default low, fields hold
  always_comb begin
    state_n = state;
    cmd_n   = cmd_code;
    addr_n  = frame_addr;
    wdata_n = frame_wdata;
    opa_n   = frame_op_a;
    opb_n   = frame_op_b;
    fun_n   = frame_fun;
    fvld_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;

    if (state == ST_IDLE) begin
      if (rx_data_vld && cmd_analyze_en) begin
        case (rx_data)
          DATA_WIDTH'(CMD_BYTE_WR):  begin cmd_n = CMD_REG_WR;  state_n = ST_GET_ADDR; end
          DATA_WIDTH'(CMD_BYTE_RD):  begin cmd_n = CMD_REG_RD;  state_n = ST_GET_ADDR; end
          DATA_WIDTH'(CMD_BYTE_ALU): begin cmd_n = CMD_ALU_OP;  state_n = ST_GET_OPA;  end
          DATA_WIDTH'(CMD_BYTE_FUN): begin cmd_n = CMD_ALU_NOP; state_n = ST_GET_FUN;  end
          default:                   begin cmd_n = CMD_NONE;    err_n   = 1'b1;        end
        endcase
      end
    end else if (rx_data_vld) begin
      fvld_n = 1'b1;
      case (state)
        ST_GET_ADDR: begin
          addr_n = rx_data[ADDR_WIDTH-1:0];
          if (cmd_code == CMD_REG_WR) state_n = ST_GET_WDATA;
          else begin state_n = ST_IDLE; done_n = 1'b1; end
        end
        ST_GET_WDATA: begin wdata_n = rx_data; state_n = ST_IDLE; done_n = 1'b1; end
        ST_GET_OPA:   begin opa_n = rx_data; state_n = ST_GET_OPB; end
        ST_GET_OPB:   begin opb_n = rx_data; state_n = ST_GET_FUN; end
        ST_GET_FUN:   begin fun_n = rx_data[FUN_WIDTH-1:0]; state_n = ST_IDLE; done_n = 1'b1; end
        default:      begin fvld_n = 1'b0; state_n = ST_IDLE; end
      endcase
    end else if (tmo_expire) begin
      // Abort: drop the command but keep whatever fields already landed
      cmd_n   = CMD_NONE;
      err_n   = 1'b1;
      state_n = ST_IDLE;
    end
  end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Randomised bench for cmd_frame_decoder with a queue-based frame model.
module tb_cmd_frame_decoder;

  localparam int T = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_data_vld = 1'b0;
  logic       cmd_analyze_en = 1'b0;
  logic [2:0] cmd_code;
  logic [3:0] frame_addr, frame_fun;
  logic [7:0] frame_wdata, frame_op_a, frame_op_b;
  logic       field_vld, frame_done, frame_err;

  cmd_frame_decoder #(
    .DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4), .TIMEOUT_CYCLES(T)
  ) dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_data_vld(rx_data_vld),
    .cmd_analyze_en(cmd_analyze_en), .cmd_code(cmd_code),
    .frame_addr(frame_addr), .frame_wdata(frame_wdata),
    .frame_op_a(frame_op_a), .frame_op_b(frame_op_b), .frame_fun(frame_fun),
    .field_vld(field_vld), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: a frame is a list of field slots still owed (0 addr, 1 wdata,
  // 2 op_a, 3 op_b, 4 fun); empty list means waiting for a command byte.
  int         owed[$];
  int         idle;
  logic [2:0] m_cmd;
  logic [3:0] m_addr, m_fun;
  logic [7:0] m_wdata, m_opa, m_opb;
  logic       m_fv, m_done, m_err;

  task automatic m_reset();
    owed.delete();
    idle = 0; m_cmd = 0; m_addr = 0; m_fun = 0;
    m_wdata = 0; m_opa = 0; m_opb = 0;
    m_fv = 0; m_done = 0; m_err = 0;
  endtask

  task automatic m_step(input logic v, input logic e, input logic [7:0] d);
    int f;
    m_fv = 0; m_done = 0; m_err = 0;
    if (owed.size() == 0) begin
      idle = 0;
      if (v && e) begin
        if      (d == 8'hAA) begin m_cmd = 3'd1; owed = '{0, 1}; end
        else if (d == 8'hBB) begin m_cmd = 3'd2; owed = '{0}; end
        else if (d == 8'hCC) begin m_cmd = 3'd3; owed = '{2, 3, 4}; end
        else if (d == 8'hDD) begin m_cmd = 3'd4; owed = '{4}; end
        else begin m_cmd = 3'd0; m_err = 1; end
      end
    end else if (v) begin
      f = owed.pop_front();
      case (f)
        0: m_addr  = d % 16;
        1: m_wdata = d;
        2: m_opa   = d;
        3: m_opb   = d;
        default: m_fun = d % 16;
      endcase
      m_fv = 1; idle = 0;
      if (owed.size() == 0) m_done = 1;
    end else if (idle == T) begin
      m_cmd = 0; m_err = 1; owed.delete(); idle = 0;
    end else begin
      idle++;
    end
  endtask

  task automatic cmp_all();
    chk("cmd_code",    32'(cmd_code),    32'(m_cmd));
    chk("frame_addr",  32'(frame_addr),  32'(m_addr));
    chk("frame_wdata", 32'(frame_wdata), 32'(m_wdata));
    chk("frame_op_a",  32'(frame_op_a),  32'(m_opa));
    chk("frame_op_b",  32'(frame_op_b),  32'(m_opb));
    chk("frame_fun",   32'(frame_fun),   32'(m_fun));
    chk("field_vld",   32'(field_vld),   32'(m_fv));
    chk("frame_done",  32'(frame_done),  32'(m_done));
    chk("frame_err",   32'(frame_err),   32'(m_err));
  endtask

  task automatic cyc(input logic v, input logic e, input logic [7:0] d);
    @(negedge CLK);
    rx_data_vld = v; cmd_analyze_en = e; rx_data = d;
    m_step(v, e, d);
    @(posedge CLK);
    #1 cmp_all();
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, 1'b1, d);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom), 8'($urandom));
  endtask

  int r;
  logic [7:0] b;

  initial begin
    m_reset();
    repeat (2) @(posedge CLK);
    #1 cmp_all();
    @(negedge CLK) RST = 1'b1;

    // Write frame
    send(8'hAA);
    chk("wr_cmd", 32'(cmd_code), 32'd1);
    send(8'h05); send(8'h3C);
    chk("wr_addr", 32'(frame_addr), 32'h5);
    chk("wr_wdata", 32'(frame_wdata), 32'h3C);
    chk("wr_done", 32'(frame_done), 32'd1);
    idle_n(2);

    // ALU frame back-to-back
    send(8'hCC); send(8'h12); send(8'h34); send(8'h01);
    chk("alu_done", 32'(frame_done), 32'd1);
    idle_n(1);
    chk("alu_cmd_held", 32'(cmd_code), 32'd3);

    // Read then no-operand ALU
    send(8'hBB); send(8'h0F);
    chk("rd_addr", 32'(frame_addr), 32'hF);
    send(8'hDD); send(8'h03);
    chk("fun_val", 32'(frame_fun), 32'h3);
    chk("fun_cmd", 32'(cmd_code), 32'd4);

    // Unknown command, then the same byte without analyze enable
    send(8'h55);
    chk("unk_err", 32'(frame_err), 32'd1);
    cyc(1'b1, 1'b0, 8'h55);
    chk("unk_quiet", 32'(frame_err), 32'd0);

    // Timeout abort
    send(8'hAA);
    idle_n(T);
    cyc(1'b0, 1'b1, 8'h00);
    chk("tmo_err", 32'(frame_err), 32'd1);
    chk("tmo_cmd", 32'(cmd_code), 32'd0);
    send(8'hBB);
    chk("tmo_idle", 32'(cmd_code), 32'd2);
    send(8'h01);

    // Byte on the expiry cycle wins
    send(8'hAA);
    idle_n(T);
    send(8'h07);
    chk("edge_addr", 32'(frame_addr), 32'h7);
    chk("edge_noerr", 32'(frame_err), 32'd0);
    send(8'h99);

    // Reset mid-frame
    send(8'hCC); send(8'h12);
    @(negedge CLK);
    rx_data_vld = 1'b0; RST = 1'b0;
    m_reset();
    #1 cmp_all();
    @(negedge CLK) RST = 1'b1;
    send(8'hDD); send(8'h02);
    chk("rst_fun", 32'(frame_fun), 32'h2);

    // Random traffic with occasional long gaps to exercise the timeout
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        idle_n($urandom_range(T - 2, T + 2));
      end else begin
        case ($urandom_range(0, 5))
          0: b = 8'hAA; 1: b = 8'hBB; 2: b = 8'hCC; 3: b = 8'hDD;
          default: b = 8'($urandom);
        endcase
        cyc(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 70), b);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
